// File: rtl/router_pkg.sv
// Shared router definitions for the 3D-torus output VC scheduler.
// Holds the port/VC counts, port index names, per-port allocation state
// and the helpers that carve the VCs of one link into two dateline sets.
package router_pkg;

    localparam int PORT_NUM = 6;
    localparam int VC_NUM   = 4;
    localparam int PTR_W    = 3;
    localparam int VC_W     = $clog2(VC_NUM);
    localparam int VC_HALF  = VC_NUM / 2;

    // Input port indices (bit positions in every PORT_NUM-wide vector)
    localparam int XPOS = 0;
    localparam int YPOS = 1;
    localparam int ZPOS = 2;
    localparam int XNEG = 3;
    localparam int YNEG = 4;
    localparam int ZNEG = 5;

    typedef logic [VC_NUM-1:0] vc_vec_t;

    // Per-port state: UNALLOC when alloc=0, otherwise ALLOC(vc)
    typedef struct packed {
        logic            alloc;
        logic [VC_W-1:0] vc;
    } port_state_t;

    // Set 0 = lower half of the VCs, set 1 = upper half
    function automatic vc_vec_t vcset_mask(input logic set);
        vc_vec_t m;
        for (int v = 0; v < VC_NUM; v++)
            m[v] = set ? (v >= VC_HALF) : (v < VC_HALF);
        return m;
    endfunction

    // Index of the lowest set bit; 0 when the mask is empty
    function automatic logic [VC_W-1:0] lowest_vc(input vc_vec_t m);
        logic [VC_W-1:0] idx;
        idx = '0;
        for (int v = VC_NUM - 1; v >= 0; v--)
            if (m[v]) idx = VC_W'(v);
        return idx;
    endfunction

endpackage

// File: rtl/out_vc_scheduler_if.sv
// Handshake bundle between the input ports / downstream VC status and the
// output VC scheduler.
//   in_valid/in_head/in_tail/in_vcset : per input port flit info
//   vc_idle/vc_full                   : downstream VC status
//   grant  : per port one-hot VC grant (slice i = grant[i])
//   stall  : per port hold request
//   vc_busy: VC owned by a packet
// master = flit/credit side driving requests, slave = scheduler.
interface out_vc_scheduler_if;
    import router_pkg::*;

    logic [PORT_NUM-1:0]             in_valid;
    logic [PORT_NUM-1:0]             in_head;
    logic [PORT_NUM-1:0]             in_tail;
    logic [PORT_NUM-1:0]             in_vcset;
    logic [VC_NUM-1:0]               vc_idle;
    logic [VC_NUM-1:0]               vc_full;
    logic [PORT_NUM-1:0][VC_NUM-1:0] grant;
    logic [PORT_NUM-1:0]             stall;
    logic [VC_NUM-1:0]               vc_busy;

    modport master (
        output in_valid, in_head, in_tail, in_vcset, vc_idle, vc_full,
        input  grant, stall, vc_busy
    );

    modport slave (
        input  in_valid, in_head, in_tail, in_vcset, vc_idle, vc_full,
        output grant, stall, vc_busy
    );

endinterface

// File: rtl/out_vc_scheduler_rr_arbiter.sv
// Round-robin arbiter with an internal pointer.
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   req      : requests (already masked by the caller)
//   upd_en   : allow pointer update when a winner exists
//   gnt_vld  : some request won this cycle
//   gnt_idx  : winner index; pointer moves to gnt_idx+1 (wrapping at N)
module rr_arbiter
    import router_pkg::*;
#(
    parameter int N = PORT_NUM,
    parameter int W = PTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         upd_en,
    output logic         gnt_vld,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] ptr;

    // Scan from the pointer; first request hit wins
    always_comb begin
        int p;
        p       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            p = (int'(ptr) + k) % N;
            if (!gnt_vld && req[p]) begin
                gnt_vld = 1'b1;
                gnt_idx = W'(p);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (upd_en && gnt_vld)
            ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end

endmodule

// File: rtl/out_vc_scheduler.sv
// Per-output-port VC scheduler. Hands the downstream VCs of one link to
// head flits from the input ports, holds a VC for the whole packet and
// frees it when the tail leaves.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of out_vc_scheduler_if (requests in,
//              grant/stall/vc_busy out)
// Allocation is registered: a head stalls in its request cycle and sees
// its grant the next cycle. One new allocation per cycle, round-robin.
module out_vc_scheduler
    import router_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    out_vc_scheduler_if.slave  bus
);

    port_state_t [PORT_NUM-1:0]           pst;
    vc_vec_t                              vc_owned;
    vc_vec_t                              vc_free;
    logic        [PORT_NUM-1:0]           req;
    logic        [PORT_NUM-1:0]           rel;
    logic        [PORT_NUM-1:0]           stall;
    logic        [PORT_NUM-1:0][VC_W-1:0] sel_vc;
    logic                                 gnt_vld;
    logic        [PTR_W-1:0]              gnt_idx;
    logic        [VC_W-1:0]               win_vc;

    // A VC freed this cycle is still owned here, so it cannot be
    // re-allocated in its release cycle.
    assign vc_free = ~vc_owned & bus.vc_idle;

    // Only ports that can actually be served enter arbitration, so a
    // requester with no free VC in its set is skipped automatically.
    always_comb begin
        vc_vec_t avail;
        avail  = '0;
        req    = '0;
        sel_vc = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            avail     = vc_free & vcset_mask(bus.in_vcset[i]);
            req[i]    = bus.in_valid[i] & bus.in_head[i] & ~pst[i].alloc & (|avail);
            sel_vc[i] = lowest_vc(avail);
        end
    end

    rr_arbiter #(.N(PORT_NUM), .W(PTR_W)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .upd_en  (1'b1),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        win_vc = '0;
        for (int i = 0; i < PORT_NUM; i++)
            if (gnt_vld && gnt_idx == PTR_W'(i)) win_vc = sel_vc[i];
    end

    always_comb begin
        bus.grant = '0;
        stall     = '0;
        rel       = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (pst[i].alloc && bus.in_valid[i])
                bus.grant[i] = vc_vec_t'(1) << pst[i].vc;
            stall[i] = bus.in_valid[i] & (~pst[i].alloc | bus.vc_full[pst[i].vc]);
            rel[i]   = bus.in_valid[i] & bus.in_tail[i] & pst[i].alloc & ~stall[i];
        end
    end

    assign bus.stall   = stall;
    assign bus.vc_busy = vc_owned;

    // Release and allocation never touch the same VC in one cycle:
    // allocation only picks VCs that are currently free.
    always_ff @(posedge clk) begin
        if (rst) begin
            pst      <= '0;
            vc_owned <= '0;
        end else begin
            for (int i = 0; i < PORT_NUM; i++) begin
                if (rel[i]) begin
                    pst[i].alloc         <= 1'b0;
                    vc_owned[pst[i].vc]  <= 1'b0;
                end
                if (gnt_vld && gnt_idx == PTR_W'(i))
                    pst[i] <= '{alloc: 1'b1, vc: win_vc};
            end
            if (gnt_vld)
                vc_owned[win_vc] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_out_vc_scheduler.sv
// Bench for out_vc_scheduler: directed scenarios plus randomized packet
// traffic, all checked each cycle against a behavioural VC ownership model.
module tb_out_vc_scheduler;
    import router_pkg::*;

    localparam logic [PORT_NUM-1:0] PM_XPOS = PORT_NUM'(1 << XPOS);
    localparam logic [PORT_NUM-1:0] PM_YPOS = PORT_NUM'(1 << YPOS);
    localparam logic [PORT_NUM-1:0] PM_ZPOS = PORT_NUM'(1 << ZPOS);
    localparam logic [PORT_NUM-1:0] PM_XNEG = PORT_NUM'(1 << XNEG);
    localparam logic [PORT_NUM-1:0] PM_YNEG = PORT_NUM'(1 << YNEG);
    localparam logic [PORT_NUM-1:0] PM_ZNEG = PORT_NUM'(1 << ZNEG);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    out_vc_scheduler_if bus();

    out_vc_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: who owns each VC (-1 free), which VC each port
    // holds (-1 none), and the next port to favour.
    int m_owner [VC_NUM];
    int m_pvc   [PORT_NUM];
    int m_ptr;

    logic [PORT_NUM*VC_NUM-1:0] s_grant;
    logic [PORT_NUM-1:0]        s_stall;
    logic [PORT_NUM-1:0]        e_stall;
    logic [VC_NUM-1:0]          s_busy;

    // random packet generator state
    int                  g_left [PORT_NUM];
    logic [PORT_NUM-1:0] gv, gh, gt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int v = 0; v < VC_NUM; v++) m_owner[v] = -1;
        for (int i = 0; i < PORT_NUM; i++) m_pvc[i] = -1;
        m_ptr = 0;
    endtask

    task automatic drive(input logic [PORT_NUM-1:0] v, input logic [PORT_NUM-1:0] h,
                         input logic [PORT_NUM-1:0] t, input logic [PORT_NUM-1:0] s);
        bus.in_valid = v;
        bus.in_head  = h;
        bus.in_tail  = t;
        bus.in_vcset = s;
    endtask

    // Called just after a falling edge with inputs applied: checks outputs
    // against the model, advances the model over the next rising edge and
    // returns at the following falling edge.
    task automatic tick();
        logic [PORT_NUM*VC_NUM-1:0] eg;
        logic [VC_NUM-1:0]          eb;
        logic [PORT_NUM-1:0]        rel;
        int                         win;
        int                         wvc;
        #1;
        eg = '0;
        eb = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            e_stall[i] = bus.in_valid[i] && (m_pvc[i] < 0 || bus.vc_full[m_pvc[i]]);
            if (bus.in_valid[i] && m_pvc[i] >= 0) eg[i*VC_NUM + m_pvc[i]] = 1'b1;
        end
        for (int v = 0; v < VC_NUM; v++) eb[v] = (m_owner[v] >= 0);
        s_grant = bus.grant;
        s_stall = bus.stall;
        s_busy  = bus.vc_busy;
        chk("grant",   32'(s_grant), 32'(eg));
        chk("stall",   32'(s_stall), 32'(e_stall));
        chk("vc_busy", 32'(s_busy),  32'(eb));

        if (rst) begin
            model_clear();
        end else begin
            rel = '0;
            for (int i = 0; i < PORT_NUM; i++)
                rel[i] = bus.in_valid[i] && bus.in_tail[i] && m_pvc[i] >= 0 && !e_stall[i];
            win = -1;
            wvc = -1;
            for (int k = 0; k < PORT_NUM && win < 0; k++) begin
                int p;
                p = (m_ptr + k) % PORT_NUM;
                if (bus.in_valid[p] && bus.in_head[p] && m_pvc[p] < 0) begin
                    int lo;
                    lo = bus.in_vcset[p] ? VC_NUM / 2 : 0;
                    for (int v = lo; v < lo + VC_NUM / 2 && wvc < 0; v++)
                        if (m_owner[v] < 0 && bus.vc_idle[v]) wvc = v;
                    if (wvc >= 0) win = p;
                end
            end
            for (int i = 0; i < PORT_NUM; i++)
                if (rel[i]) begin
                    m_owner[m_pvc[i]] = -1;
                    m_pvc[i]          = -1;
                end
            if (win >= 0) begin
                m_owner[wvc] = win;
                m_pvc[win]   = wvc;
                m_ptr        = (win + 1) % PORT_NUM;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive('0, '0, '0, '0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        drive('0, '0, '0, '0);
        bus.vc_idle = '1;
        bus.vc_full = '0;
        gv = '0; gh = '0; gt = '0;
        for (int i = 0; i < PORT_NUM; i++) g_left[i] = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_clear();

        // reset state: nothing allocated, stall follows in_valid
        drive(6'h2A, 6'h2A, '0, '0);
        tick();
        chk("rst_stall", 32'(s_stall), 32'h2A);
        chk("rst_grant", 32'(s_grant), 32'h0);
        rst = 1'b0;

        // single packet on port 0
        do_reset();
        drive(PM_XPOS, PM_XPOS, '0, '0);      tick(); chk("sp_stall_c1", 32'(s_stall[0]), 32'h1);
        drive(PM_XPOS, '0, '0, '0);           tick(); chk("sp_grant_c2", 32'(s_grant[3:0]), 32'h1);
        drive(PM_XPOS, '0, PM_XPOS, '0);      tick(); chk("sp_grant_c3", 32'(s_grant[3:0]), 32'h1);
        drive('0, '0, '0, '0);                tick(); chk("sp_busy_c4",  32'(s_busy), 32'h0);

        // contention: ports 1,2,3 all want set 0
        do_reset();
        drive(PM_YPOS|PM_ZPOS|PM_XNEG, PM_YPOS|PM_ZPOS|PM_XNEG, '0, '0); tick();
        chk("ct_stall_c1", 32'(s_stall), 32'h0E);
        drive(PM_YPOS|PM_ZPOS|PM_XNEG, PM_YPOS|PM_ZPOS|PM_XNEG, '0, '0); tick();
        chk("ct_grant_c2", 32'(s_grant), 32'h010);
        drive(PM_YPOS|PM_ZPOS|PM_XNEG, PM_ZPOS|PM_XNEG, PM_YPOS, '0);     tick();
        chk("ct_grant_c3", 32'(s_grant), 32'h210);
        chk("ct_stall_c3", 32'(s_stall), 32'h08);
        drive(PM_ZPOS|PM_XNEG, PM_XNEG, '0, '0);                          tick();
        chk("ct_p3_wait",  32'(s_stall), 32'h08);
        drive(PM_ZPOS|PM_XNEG, PM_XNEG, PM_ZPOS, '0);                     tick();
        chk("ct_grant_c5", 32'(s_grant), 32'h1200);
        drive(PM_XNEG, '0, PM_XNEG, '0);                                  tick();
        drive('0, '0, '0, '0);                                            tick();
        chk("ct_busy_end", 32'(s_busy), 32'h0);

        // dateline set 1 on port 4
        do_reset();
        drive(PM_YNEG, PM_YNEG, '0, PM_YNEG); tick();
        drive(PM_YNEG, PM_YNEG, '0, PM_YNEG); tick();
        chk("dl_grant", 32'(s_grant[19:16]), 32'h4);
        chk("dl_busy",  32'(s_busy), 32'h4);
        drive(PM_YNEG, '0, PM_YNEG, '0);      tick();
        drive('0, '0, '0, '0);                tick();

        // backpressure on VC1 during tail (VC0 held non-idle)
        do_reset();
        bus.vc_idle = 4'b1110;
        drive(PM_XPOS, PM_XPOS, '0, '0);      tick();
        drive(PM_XPOS, PM_XPOS, '0, '0);      tick(); chk("bp_grant", 32'(s_grant), 32'h2);
        bus.vc_full = 4'b0010;
        drive(PM_XPOS, '0, PM_XPOS, '0);      tick(); chk("bp_stall1", 32'(s_stall), 32'h1);
        drive(PM_XPOS, '0, PM_XPOS, '0);      tick(); chk("bp_busy",   32'(s_busy), 32'h2);
        bus.vc_full = '0;
        drive(PM_XPOS, '0, PM_XPOS, '0);      tick(); chk("bp_go",     32'(s_stall), 32'h0);
        drive('0, '0, '0, '0);                tick(); chk("bp_freed",  32'(s_busy), 32'h0);
        bus.vc_idle = '1;

        // fairness: ports 0 and 5 issue single flits continuously
        do_reset();
        drive(PM_XPOS|PM_ZNEG, PM_XPOS|PM_ZNEG, PM_XPOS|PM_ZNEG, '0);
        tick();
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("fair_grant", 32'(s_grant), (c % 2 == 0) ? 32'h000001 : 32'h200000);
        end
        drive('0, '0, '0, '0); tick();

        // reset in the middle of a packet
        do_reset();
        drive(PM_XPOS, PM_XPOS, '0, '0);      tick();
        drive(PM_XPOS, PM_XPOS, '0, '0);      tick();
        rst = 1'b1;
        drive(PM_XPOS, '0, '0, '0);           tick();
        rst = 1'b0;
        drive(PM_XPOS, '0, '0, '0);           tick();
        chk("rm_busy",  32'(s_busy),  32'h0);
        chk("rm_grant", 32'(s_grant), 32'h0);
        drive(PM_XPOS|PM_ZPOS, PM_ZPOS, '0, '0); tick();
        drive(PM_XPOS|PM_ZPOS, PM_ZPOS, '0, '0); tick();
        chk("rm_new_grant", 32'(s_grant), 32'h100);
        drive(PM_XPOS|PM_ZPOS, '0, PM_ZPOS, '0); tick();
        drive('0, '0, '0, '0);                   tick();

        // randomized packet traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic perr;
            perr = 1'b0;
            for (int i = 0; i < PORT_NUM; i++) begin
                if (!gv[i] && $urandom_range(0, 2) == 0) begin
                    g_left[i] = $urandom_range(1, 4);
                    if (m_pvc[i] >= 0) perr = 1'b1;
                    gv[i] = 1'b1;
                    gh[i] = 1'b1;
                    gt[i] = (g_left[i] == 1);
                end
            end
            for (int v = 0; v < VC_NUM; v++) begin
                bus.vc_idle[v] = ($urandom_range(0, 7) != 0);
                bus.vc_full[v] = ($urandom_range(0, 3) == 0);
            end
            drive(gv, gh, gt, PORT_NUM'($urandom));
            tick();
            chk("proto_head_alloc", 32'(perr), 32'h0);
            for (int i = 0; i < PORT_NUM; i++) begin
                if (gv[i] && !e_stall[i]) begin
                    g_left[i]--;
                    if (g_left[i] == 0) begin
                        gv[i] = 1'b0;
                        gh[i] = 1'b0;
                        gt[i] = 1'b0;
                    end else begin
                        gh[i] = 1'b0;
                        gt[i] = (g_left[i] == 1);
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
